// File: rtl/sr_seq_driver_pkg.sv
// Shared constants and state encoding for the SR flop command driver.
// The sr codes mirror the set/reset pins of the downstream flop.
package sr_drv_pkg;

  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_RESET   = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DWELL = 2'd2,
    ST_DONE  = 2'd3
  } sr_state_e;

endpackage

// File: rtl/sr_seq_driver_if.sv
// Word handshake into the SR command driver.
// The producer uses the master view and the driver uses the slave view.
interface sr_seq_driver_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/sr_seq_driver_cmd_encode.sv
// Maps a target bit onto the sr code for the downstream flop.
// Uses the shadow q so a bit that is already held costs no command.
module sr_cmd_encode
  import sr_drv_pkg::*;
(
  input  logic       b,
  input  logic       q_model,
  input  logic       q_known,
  output logic [1:0] code,
  output logic       counts
);

  always_comb begin
    code   = SR_HOLD;
    counts = 1'b0;
    if (!q_known || (b != q_model)) begin
      code   = b ? SR_SET : SR_RESET;
      counts = 1'b1;
    end
  end

endmodule

// File: rtl/sr_seq_driver.sv
// Replays a WIDTH-bit word MSB-first onto an SR flop, one bit per DWELL cycles,
// issuing set/reset only when the shadow q has to change.
//
// state    | meaning
// ST_IDLE  | waiting for a word, in_ready high
// ST_DRIVE | first cycle of a bit, its command is on sr
// ST_DWELL | remaining DWELL-1 cycles of a bit, sr holds
// ST_DONE  | one-cycle done pulse after the last bit
module sr_seq_driver
  import sr_drv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DWELL = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  sr_seq_driver_if.slave               bus,
  output logic [1:0]                   sr,
  output logic                         q_model,
  output logic                         q_known,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   cmd_count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = $clog2(DWELL + 1);

  sr_state_e         state;
  sr_state_e         state_d;
  logic [WIDTH-1:0]  shift;
  logic [CW-1:0]     bit_cnt;
  logic [DW-1:0]     dwell_cnt;

  logic              accept;
  logic              load_bit;
  logic              dwell_ld;
  logic              b_next;
  logic [1:0]        code;
  logic              counts;

  assign accept       = (state == ST_IDLE) && bus.in_valid;
  assign bus.in_ready = (state == ST_IDLE);
  assign busy         = (state == ST_DRIVE) || (state == ST_DWELL);

  // Remaining bits sit left-justified, so the next bit is always the MSB.
  assign b_next = (state == ST_IDLE) ? bus.in_data[WIDTH-1] : shift[WIDTH-1];

  sr_cmd_encode u_encode (
    .b       (b_next),
    .q_model (q_model),
    .q_known (q_known),
    .code    (code),
    .counts  (counts)
  );

  always_comb begin
    state_d  = state;
    load_bit = 1'b0;
    dwell_ld = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d  = ST_DRIVE;
          load_bit = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (DWELL > 1) begin
          state_d  = ST_DWELL;
          dwell_ld = 1'b1;
        end else if (bit_cnt != '0) begin
          load_bit = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DWELL: begin
        if (dwell_cnt == DW'(1)) begin
          if (bit_cnt != '0) begin
            state_d  = ST_DRIVE;
            load_bit = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= SR_HOLD;
      q_model   <= 1'b0;
      q_known   <= 1'b0;
      done      <= 1'b0;
      cmd_count <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
      dwell_cnt <= '0;
    end else begin
      done <= (state_d == ST_DONE);
      sr   <= load_bit ? code : SR_HOLD;

      if (load_bit) begin
        q_model <= b_next;
        q_known <= 1'b1;
        shift   <= (accept ? bus.in_data : shift) << 1;
        bit_cnt <= accept ? CW'(WIDTH - 1) : (bit_cnt - CW'(1));
      end

      if (accept) begin
        cmd_count <= CW'(counts);
      end else if (load_bit && counts) begin
        cmd_count <= cmd_count + CW'(1);
      end

      if (dwell_ld) begin
        dwell_cnt <= DW'(DWELL - 1);
      end else if (state == ST_DWELL) begin
        dwell_cnt <= dwell_cnt - DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sr_seq_driver.sv
// Bench for sr_seq_driver: four instances with DWELL 1..4, a model SR flop on
// each, and a per-cycle scoreboard of the expected sr/done/busy/count stream.
module tb_sr_seq_driver;
  import sr_drv_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [1:0] sr;
    logic       done;
    logic       busy;
    logic [3:0] cnt;
    logic       qm;
    logic       chk_q;
    logic       q;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [4:1]   vld;
  logic [W-1:0] dat [1:4];
  logic [4:1]   rdy;
  logic [1:0]   sr_o [1:4];
  logic [4:1]   qm_o, qk_o, busy_o, done_o;
  logic [3:0]   cnt_o [1:4];
  logic [4:1]   fq;

  for (genvar g = 1; g <= 4; g++) begin : u
    sr_seq_driver_if #(.WIDTH(W)) bus ();
    assign bus.in_valid = vld[g];
    assign bus.in_data  = dat[g];
    assign rdy[g]       = bus.in_ready;

    sr_seq_driver #(.WIDTH(W), .DWELL(g)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .sr        (sr_o[g]),
      .q_model   (qm_o[g]),
      .q_known   (qk_o[g]),
      .busy      (busy_o[g]),
      .done      (done_o[g]),
      .cmd_count (cnt_o[g])
    );
  end

  // Model of the driven SR flops (no reset, like the real part).
  always @(posedge clk) begin
    for (int g = 1; g <= 4; g++) begin
      if (sr_o[g] == SR_SET) fq[g] <= 1'b1;
      else if (sr_o[g] == SR_RESET) fq[g] <= 1'b0;
    end
  end

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sbq[$];
  int   act = 1;
  logic [4:1] mq, mk, pq, pk;
  logic [3:0] lastcnt [1:4];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    sbq.delete();
    mq = '0;
    mk = '0;
    pq = '0;
    pk = '0;
    for (int g = 1; g <= 4; g++) lastcnt[g] = 4'd0;
  endtask

  task automatic tick();
    exp_t e;
    bit   have;
    @(negedge clk);
    have = (sbq.size() > 0);
    if (have) e = sbq.pop_front();
    for (int g = 1; g <= 4; g++) begin
      check($sformatf("sr_legal[%0d]", g), 16'(sr_o[g] === SR_ILLEGAL), 16'd0);
      if (pk[g]) check($sformatf("q_lead[%0d]", g), 16'(fq[g]), 16'(pq[g]));
      pq[g] = qm_o[g];
      pk[g] = qk_o[g];
      if (g == act && have) begin
        check($sformatf("sr[%0d]", g), 16'(sr_o[g]), 16'(e.sr));
        check($sformatf("done[%0d]", g), 16'(done_o[g]), 16'(e.done));
        check($sformatf("busy[%0d]", g), 16'(busy_o[g]), 16'(e.busy));
        check($sformatf("ready[%0d]", g), 16'(rdy[g]), 16'd0);
        check($sformatf("cnt[%0d]", g), 16'(cnt_o[g]), 16'(e.cnt));
        check($sformatf("q_model[%0d]", g), 16'(qm_o[g]), 16'(e.qm));
        check($sformatf("q_known[%0d]", g), 16'(qk_o[g]), 16'd1);
        if (e.chk_q) check($sformatf("slot_q[%0d]", g), 16'(fq[g]), 16'(e.q));
        lastcnt[g] = e.cnt;
      end else begin
        check($sformatf("idle_sr[%0d]", g), 16'(sr_o[g]), 16'(SR_HOLD));
        check($sformatf("idle_done[%0d]", g), 16'(done_o[g]), 16'd0);
        check($sformatf("idle_busy[%0d]", g), 16'(busy_o[g]), 16'd0);
        check($sformatf("idle_ready[%0d]", g), 16'(rdy[g]), 16'd1);
        check($sformatf("idle_cnt[%0d]", g), 16'(cnt_o[g]), 16'(lastcnt[g]));
        check($sformatf("idle_qk[%0d]", g), 16'(qk_o[g]), 16'(mk[g]));
        check($sformatf("idle_qm[%0d]", g), 16'(qm_o[g]), 16'(mq[g]));
      end
    end
  endtask

  // Builds the expected cycle stream for one word on instance g (DWELL = g).
  task automatic queue_word(input int g, input logic [W-1:0] word);
    logic [1:0] cmdv [W];
    logic [3:0] cntv [W];
    logic [3:0] cnt;
    logic       b;
    exp_t       e;
    cnt = 4'd0;
    for (int i = 0; i < W; i++) begin
      b = word[W-1-i];
      if (!mk[g] || b != mq[g]) begin
        cmdv[i] = b ? SR_SET : SR_RESET;
        cnt++;
      end else begin
        cmdv[i] = SR_HOLD;
      end
      cntv[i] = cnt;
      mq[g] = b;
      mk[g] = 1'b1;
    end
    for (int j = 0; j <= W * g; j++) begin
      e = '{default: '0};
      if (j < W * g) begin
        e.sr   = (j % g == 0) ? cmdv[j / g] : SR_HOLD;
        e.busy = 1'b1;
        e.cnt  = cntv[j / g];
        e.qm   = word[W-1-(j / g)];
      end else begin
        e.done = 1'b1;
        e.cnt  = cntv[W-1];
        e.qm   = word[0];
      end
      if (j >= 1 && (j - 1) % g == 0) begin
        e.chk_q = 1'b1;
        e.q     = word[W-1-((j - 1) / g)];
      end
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (sbq.size() > 0 && guard < 200) begin
      tick();
      guard++;
    end
    if (guard == 200) check("drain_timeout", 16'(sbq.size()), 16'd0);
  endtask

  task automatic send(input int g, input logic [W-1:0] word);
    int guard = 0;
    while (!rdy[g] && guard < 100) begin
      tick();
      guard++;
    end
    if (guard == 100) check("ready_timeout", 16'(rdy[g]), 16'd1);
    act    = g;
    vld[g] = 1'b1;
    dat[g] = word;
    queue_word(g, word);
    tick();
    vld[g] = 1'b0;
  endtask

  int acc[$];

  initial begin
    vld = '0;
    for (int g = 1; g <= 4; g++) dat[g] = '0;
    clear_model();

    // Reset values, asserted between clock edges
    #2 rst_n = 1'b0;
    #1;
    for (int g = 1; g <= 4; g++) begin
      check($sformatf("rst_sr[%0d]", g), 16'(sr_o[g]), 16'd0);
      check($sformatf("rst_qm[%0d]", g), 16'(qm_o[g]), 16'd0);
      check($sformatf("rst_qk[%0d]", g), 16'(qk_o[g]), 16'd0);
      check($sformatf("rst_busy[%0d]", g), 16'(busy_o[g]), 16'd0);
      check($sformatf("rst_done[%0d]", g), 16'(done_o[g]), 16'd0);
      check($sformatf("rst_cnt[%0d]", g), 16'(cnt_o[g]), 16'd0);
      check($sformatf("rst_ready[%0d]", g), 16'(rdy[g]), 16'd1);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // First word after reset, then an all-hold word
    send(1, 8'hA5);
    drain();
    check("a5_cmd_count", 16'(cnt_o[1]), 16'd7);
    send(1, 8'hFF);
    drain();
    check("ff_cmd_count", 16'(cnt_o[1]), 16'd0);
    check("ff_flop_q", 16'(fq[1]), 16'd1);

    // DWELL=3 straight after reset
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    clear_model();
    tick();
    send(3, 8'h00);
    drain();
    check("dwell_cmd_count", 16'(cnt_o[3]), 16'd1);

    // Back-to-back with in_valid held high
    act = 1;
    vld[1] = 1'b1;
    dat[1] = 8'($urandom);
    for (int c = 0; c < 40; c++) begin
      if (rdy[1]) begin
        queue_word(1, dat[1]);
        acc.push_back(c);
        tick();
        dat[1] = 8'($urandom);
      end else begin
        tick();
      end
    end
    vld[1] = 1'b0;
    drain();
    check("b2b_accepts", 16'(acc.size()), 16'd4);
    for (int i = 1; i < acc.size(); i++)
      check("b2b_spacing", 16'(acc[i] - acc[i-1]), 16'd10);

    // Reset in the middle of bit 3
    send(1, 8'hFF);
    drain();
    send(1, 8'hE0);
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sr", 16'(sr_o[1]), 16'd0);
    check("midrst_busy", 16'(busy_o[1]), 16'd0);
    check("midrst_qk", 16'(qk_o[1]), 16'd0);
    check("midrst_done", 16'(done_o[1]), 16'd0);
    #1 rst_n = 1'b1;
    clear_model();
    for (int i = 0; i < 12; i++) tick();
    check("midrst_flop_q", 16'(fq[1]), 16'd1);
    send(1, 8'h80);
    drain();
    check("after_rst_cnt", 16'(cnt_o[1]), 16'd2);

    // Random words across DWELL 1..4
    for (int n = 0; n < 12; n++) begin
      send($urandom_range(1, 4), 8'($urandom));
      drain();
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
